// File: rtl/spy_pkg.sv
// spy_pkg: shared types and constants for the path spy sequencer
package spy_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, CMP = 2'd2, DONE = 2'd3} state_e;
  typedef logic [1:0] sig_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spy_sync2.sv
// spy_sync2: multi-flop synchroniser for the asynchronous path output
module spy_sync2
  import spy_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] ff_q;
  // shift the raw input through the synchroniser chain
  always_ff @(posedge clk)
    if (rst) ff_q <= '0;
    else ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
  assign q_o = ff_q[SYNC_STAGES-1];
endmodule

// File: rtl/spy_path_sequencer.sv
// spy_path_sequencer: reference/armed launch sequencer comparing path transfer signatures
module spy_path_sequencer
  import spy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int NUM_TRIALS    = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cfg_trig,
  input  logic             path_out,
  output logic             launch,
  output logic             ht_in1,
  output logic             ht_in2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] stuck_cnt,
  output logic [1:0]       ref_sig,
  output logic [1:0]       arm_sig
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(NUM_TRIALS + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic [TW-1:0]    trial_q, trial_d;
  logic [1:0]       trig_q, trig_d;
  logic [3:0]       samp_q, samp_d;
  logic [CNT_W-1:0] mism_q, mism_d, stuck_q, stuck_d;
  sig_t             ref_q, ref_d, arm_q, arm_d;
  logic             sync_o, last_cnt, sig_diff, sig_flat;
  spy_sync2 u_sync (.clk(clk), .rst(rst), .d_i(path_out), .q_o(sync_o));
  assign last_cnt = cnt_q == SW'(SETTLE_CYCLES - 1);
  assign sig_diff = samp_q[3:2] != samp_q[1:0];
  assign sig_flat = (samp_q[3] == samp_q[2]) || (samp_q[1] == samp_q[0]);
  // sequence steps/phases/trials; samples land at the end of each step, bit 3 = first step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    trial_d = trial_q;
    trig_d  = trig_q;
    samp_d  = samp_q;
    mism_d  = mism_q;
    stuck_d = stuck_q;
    ref_d   = ref_q;
    arm_d   = arm_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = STEP;
        cnt_d   = '0;
        step_d  = '0;
        trial_d = '0;
        trig_d  = cfg_trig;
        mism_d  = '0;
        stuck_d = '0;
      end
      STEP: begin
        cnt_d = last_cnt ? '0 : cnt_q + SW'(1);
        if (last_cnt) begin
          samp_d[2'd3 - step_q] = sync_o;
          step_d = step_q + 2'd1;
          state_d = (step_q == 2'd3) ? CMP : STEP;
        end
      end
      CMP: begin
        ref_d   = samp_q[3:2];
        arm_d   = samp_q[1:0];
        mism_d  = (sig_diff && mism_q != CMAX) ? mism_q + CNT_W'(1) : mism_q;
        stuck_d = (sig_flat && stuck_q != CMAX) ? stuck_q + CNT_W'(1) : stuck_q;
        trial_d = trial_q + TW'(1);
        state_d = (trial_q == TW'(NUM_TRIALS - 1)) ? DONE : STEP;
      end
      default: state_d = IDLE;
    endcase
  end
  // register all sequencer state
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      trial_q <= '0;
      trig_q  <= '0;
      samp_q  <= '0;
      mism_q  <= '0;
      stuck_q <= '0;
      ref_q   <= '0;
      arm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      trial_q <= trial_d;
      trig_q  <= trig_d;
      samp_q  <= samp_d;
      mism_q  <= mism_d;
      stuck_q <= stuck_d;
      ref_q   <= ref_d;
      arm_q   <= arm_d;
    end
  assign launch           = (state_q == STEP) && step_q[0];
  assign {ht_in1, ht_in2} = ((state_q == STEP) && step_q[1]) ? trig_q : 2'b00;
  assign busy             = (state_q == STEP) || (state_q == CMP);
  assign done             = state_q == DONE;
  assign mismatch_cnt     = mism_q;
  assign stuck_cnt        = stuck_q;
  assign ref_sig          = ref_q;
  assign arm_sig          = arm_q;
endmodule

// File: tb/tb_spy_path_sequencer.sv
// tb_spy_path_sequencer: randomized runs against a rule-level model of trials and signatures
module tb_spy_path_sequencer;
  localparam int S   = 8;
  localparam int NT  = 16;
  localparam int LAT = 1 + NT * (4 * S + 1);
  localparam int NT2 = 10;
  localparam int LAT2 = 1 + NT2 * (4 * S + 1);
  logic clk = 0, rst = 1, start = 0, start2 = 0;
  logic [1:0] cfg_trig = 0;
  logic path_out, launch, ht_in1, ht_in2, busy, done;
  logic [7:0] mism, stuck;
  logic [1:0] ref_sig, arm_sig;
  logic path2, launch2, h21, h22, busy2, done2;
  logic [2:0] mism2, stuck2;
  logic [1:0] ref2, arm2;
  logic [1:0] dl1 = 0, dl2 = 0;
  int mode1 = 0, mode2 = 0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  spy_path_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_trig(cfg_trig), .path_out(path_out),
    .launch(launch), .ht_in1(ht_in1), .ht_in2(ht_in2), .busy(busy), .done(done),
    .mismatch_cnt(mism), .stuck_cnt(stuck), .ref_sig(ref_sig), .arm_sig(arm_sig));
  spy_path_sequencer #(.SETTLE_CYCLES(S), .NUM_TRIALS(NT2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cfg_trig(cfg_trig), .path_out(path2),
    .launch(launch2), .ht_in1(h21), .ht_in2(h22), .busy(busy2), .done(done2),
    .mismatch_cnt(mism2), .stuck_cnt(stuck2), .ref_sig(ref2), .arm_sig(arm2));
  // steady-state path response: 0 trojan model, 1 tied low, 2 tied high, 3 plain buffer
  function automatic logic path_val(input int m, input logic l, input logic [1:0] t);
    return m == 0 ? l ^ ~(t[1] & t[0]) : m == 1 ? 1'b0 : m == 2 ? 1'b1 : l;
  endfunction
  always @(posedge clk) begin
    dl1 <= {dl1[0], path_val(mode1, launch, {ht_in1, ht_in2})};
    dl2 <= {dl2[0], path_val(mode2, launch2, {h21, h22})};
  end
  assign path_out = dl1[1];
  assign path2    = dl2[1];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_launch"}, launch, 0);
    chk({tag, "_ht"}, {ht_in1, ht_in2}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnts"}, {mism, stuck}, 0);
    chk({tag, "_sigs"}, {ref_sig, arm_sig}, 0);
  endtask
  task automatic run(input int m, input logic [1:0] trig, input bit disturb, input int rst_at);
    logic [1:0] er, ea;
    int n, em, es, dn;
    er = {path_val(m, 0, 2'b00), path_val(m, 1, 2'b00)};
    ea = {path_val(m, 0, trig), path_val(m, 1, trig)};
    em = (er != ea) ? NT : 0;
    es = (er[1] == er[0] || ea[1] == ea[0]) ? NT : 0;
    mode1 = m;
    cfg_trig = trig;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_rise", busy, 1);
    n = 1;
    while (!done && n < LAT + 50) begin
      if (n == 5) chk("ref_drive", {launch, ht_in1, ht_in2}, 0);
      if (n == 20) chk("arm_low", {launch, ht_in1, ht_in2}, {1'b0, trig});
      if (n == 28) chk("arm_high", {launch, ht_in1, ht_in2}, {1'b1, trig});
      if (disturb && n == 100) begin start = 1; cfg_trig = ~trig; end
      if (disturb && n == 101) start = 0;
      if (rst_at != 0 && n == rst_at) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_reset("mid_rst");
        dn = 0;
        for (int i = 0; i < LAT + 50; i++) begin
          @(posedge clk); #1;
          dn += int'(done);
        end
        chk("no_done_after_rst", dn, 0);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_latency", n, LAT);
    chk("done_busy", busy, 0);
    chk("mismatch_cnt", mism, em);
    chk("stuck_cnt", stuck, es);
    chk("ref_sig", ref_sig, er);
    chk("arm_sig", arm_sig, ea);
    @(posedge clk); #1;
    chk("done_pulse", {done, busy}, 0);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 0;
    @(posedge clk); #1;
    run(0, 2'b11, 0, 0);
    run(0, 2'b01, 0, 0);
    run(1, 2'($urandom_range(0, 3)), 0, 0);
    run(0, 2'b11, 1, 0);
    for (int r = 0; r < 4; r++) run(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, 0);
    run(0, 2'b11, 0, 5 * (4 * S + 1) + 20);
    run(0, 2'b11, 0, 0);
    mode2 = 0;
    cfg_trig = 2'b11;
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    n = 1;
    while (!done2 && n < LAT2 + 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sat_latency", n, LAT2);
    chk("sat_mismatch", mism2, 7);
    chk("sat_stuck", stuck2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
